// File: rtl/z80_pkg.sv
// z80_pkg: shared definitions for the Z80 register-bank micro-sequencer.
//   - Bank index constants (one-hot bit position of each register in WE/RE)
//   - Sequencer state enum and opcode-class enum
//   - Opcode constants
//   - reg_code_to_idx(): Z80 3-bit register field -> bank index + valid flag
package z80_pkg;

    localparam logic [3:0] IDX_W  = 4'd0;
    localparam logic [3:0] IDX_Z  = 4'd1;
    localparam logic [3:0] IDX_A  = 4'd2;
    localparam logic [3:0] IDX_F  = 4'd3;
    localparam logic [3:0] IDX_B  = 4'd4;
    localparam logic [3:0] IDX_C  = 4'd5;
    localparam logic [3:0] IDX_D  = 4'd6;
    localparam logic [3:0] IDX_E  = 4'd7;
    localparam logic [3:0] IDX_H  = 4'd8;
    localparam logic [3:0] IDX_L  = 4'd9;
    localparam logic [3:0] IDX_IX = 4'd10;
    localparam logic [3:0] IDX_IY = 4'd11;
    localparam logic [3:0] IDX_SP = 4'd12;
    localparam logic [3:0] IDX_PC = 4'd13;

    localparam logic [7:0] OP_LD_SP_HL = 8'hF9;
    localparam logic [7:0] OP_HALT     = 8'h76;

    typedef enum logic [2:0] {
        IDLE,
        MV_SRC,
        MV_DST,
        LD_IMM,
        SP_HI,
        SP_LO,
        REJECT
    } seq_state_t;

    // Instruction class produced by the decoder.
    typedef enum logic [1:0] {
        KIND_MOVE,
        KIND_IMM,
        KIND_SPHL,
        KIND_REJECT
    } op_kind_t;

    typedef struct packed {
        logic       valid;
        logic [3:0] idx;
    } reg_sel_t;

    // Code 110 addresses memory via (HL) and has no bank register.
    function automatic reg_sel_t reg_code_to_idx(input logic [2:0] code);
        reg_sel_t sel;
        sel.valid = 1'b1;
        sel.idx   = IDX_W;
        case (code)
            3'b000:  sel.idx = IDX_B;
            3'b001:  sel.idx = IDX_C;
            3'b010:  sel.idx = IDX_D;
            3'b011:  sel.idx = IDX_E;
            3'b100:  sel.idx = IDX_H;
            3'b101:  sel.idx = IDX_L;
            3'b111:  sel.idx = IDX_A;
            default: sel.valid = 1'b0;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/z80_ld_decode.sv
// z80_ld_decode: combinational classifier for 8-bit register loads.
//   opcode  in   opcode byte
//   op_kind out  KIND_MOVE (LD r,r'), KIND_IMM (LD r,n), KIND_SPHL (LD SP,HL),
//                KIND_REJECT (anything else)
//   src_idx out  bank index of source register (LD r,r')
//   dst_idx out  bank index of destination register (LD r,r' / LD r,n)
module z80_ld_decode
    import z80_pkg::*;
#(
    parameter int SUPPORT_SPHL = 1
) (
    input  logic [7:0] opcode,
    output op_kind_t   op_kind,
    output logic [3:0] src_idx,
    output logic [3:0] dst_idx
);

    reg_sel_t src_sel;
    reg_sel_t dst_sel;

    always_comb begin
        src_sel = reg_code_to_idx(opcode[2:0]);
        dst_sel = reg_code_to_idx(opcode[5:3]);
        src_idx = src_sel.idx;
        dst_idx = dst_sel.idx;
        op_kind = KIND_REJECT;

        // HALT sits in the LD r,r' encoding space (both fields 110); the
        // valid flags already exclude it, the explicit compare documents it.
        if (opcode[7:6] == 2'b01 && opcode != OP_HALT &&
            src_sel.valid && dst_sel.valid) begin
            op_kind = KIND_MOVE;
        end else if (opcode[7:6] == 2'b00 && opcode[2:0] == 3'b110 &&
                     dst_sel.valid) begin
            op_kind = KIND_IMM;
        end else if (opcode == OP_LD_SP_HL && SUPPORT_SPHL != 0) begin
            op_kind = KIND_SPHL;
        end
    end

endmodule

// File: rtl/z80_regbank_seq.sv
// z80_regbank_seq: micro-sequencer driving the register bank's one-hot
// write (WE) and read/bus-drive (RE) enables for 8-bit register loads.
// All transfers go over the single internal data bus; LD r,r' bounces
// through the temporary register W.
//   clk, reset    clock; synchronous active-low reset
//   op_valid/op_ready, opcode, imm   opcode handshake (sampled on accept)
//   hold          stall: freezes the sequencer and blanks enables
//   WE, RE        one-hot register enables (bank index map in z80_pkg)
//   bus_drv_en/bus_drv_val  sequencer drives the immediate onto the bus
//   hi_sel        byte lane for 16-bit register writes (1 = high byte)
//   done, op_err  completion pulse; op_err marks a rejected opcode
//
// state_reg holds the step that will be issued at the next edge. Every
// output is the registered image of the step issued at that edge, so an
// accepted opcode shows its first step in the very next cycle. A step
// is issued only when hold is low; otherwise it stays pending and is
// re-issued in full later.
module z80_regbank_seq
    import z80_pkg::*;
#(
    parameter int NUM_EN       = 16,
    parameter int SUPPORT_SPHL = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [7:0]        opcode,
    input  logic [7:0]        imm,
    input  logic              hold,
    output logic [NUM_EN-1:0] WE,
    output logic [NUM_EN-1:0] RE,
    output logic              bus_drv_en,
    output logic [7:0]        bus_drv_val,
    output logic              hi_sel,
    output logic              done,
    output logic              op_err
);

    seq_state_t  state_reg;
    seq_state_t  state_next;
    logic [3:0]  src_idx_reg;
    logic [3:0]  dst_idx_reg;
    logic [7:0]  imm_reg;

    op_kind_t    dec_kind;
    logic [3:0]  dec_src;
    logic [3:0]  dec_dst;

    logic        accept;
    seq_state_t  step;
    logic [3:0]  step_src;
    logic [3:0]  step_dst;
    logic [7:0]  step_imm;

    logic        we_en;
    logic [3:0]  we_idx;
    logic        re_en;
    logic [3:0]  re_idx;
    logic        drv_en_next;
    logic [7:0]  drv_val_next;
    logic        hi_sel_next;
    logic        done_next;
    logic        op_err_next;
    logic        op_ready_next;

    logic [NUM_EN-1:0] we_next;
    logic [NUM_EN-1:0] re_next;

    logic [NUM_EN-1:0] we_reg;
    logic [NUM_EN-1:0] re_reg;
    logic              bus_drv_en_reg;
    logic [7:0]        bus_drv_val_reg;
    logic              hi_sel_reg;
    logic              done_reg;
    logic              op_err_reg;
    logic              op_ready_reg;

    z80_ld_decode #(
        .SUPPORT_SPHL(SUPPORT_SPHL)
    ) u_decode (
        .opcode (opcode),
        .op_kind(dec_kind),
        .src_idx(dec_src),
        .dst_idx(dec_dst)
    );

    // op_ready is only ever high in IDLE, so accept never interrupts a step.
    assign accept = op_valid && op_ready_reg;

    always_comb begin
        // Step to issue: either the pending one, or the first step of the
        // opcode being accepted right now (taken straight from the inputs).
        step     = state_reg;
        step_src = src_idx_reg;
        step_dst = dst_idx_reg;
        step_imm = imm_reg;
        if (accept) begin
            step_src = dec_src;
            step_dst = dec_dst;
            step_imm = imm;
            unique case (dec_kind)
                KIND_MOVE: step = MV_SRC;
                KIND_IMM:  step = LD_IMM;
                KIND_SPHL: step = SP_HI;
                default:   step = REJECT;
            endcase
        end

        we_en        = 1'b0;
        we_idx       = IDX_W;
        re_en        = 1'b0;
        re_idx       = IDX_W;
        drv_en_next  = 1'b0;
        drv_val_next = 8'h00;
        hi_sel_next  = 1'b0;
        done_next    = 1'b0;
        op_err_next  = 1'b0;
        state_next   = IDLE;

        unique case (step)
            MV_SRC: begin
                re_en      = 1'b1;
                re_idx     = step_src;
                we_en      = 1'b1;
                we_idx     = IDX_W;
                state_next = MV_DST;
            end
            MV_DST: begin
                re_en     = 1'b1;
                re_idx    = IDX_W;
                we_en     = 1'b1;
                we_idx    = step_dst;
                done_next = 1'b1;
            end
            LD_IMM: begin
                drv_en_next  = 1'b1;
                drv_val_next = step_imm;
                we_en        = 1'b1;
                we_idx       = step_dst;
                done_next    = 1'b1;
            end
            SP_HI: begin
                re_en       = 1'b1;
                re_idx      = IDX_H;
                we_en       = 1'b1;
                we_idx      = IDX_SP;
                hi_sel_next = 1'b1;
                state_next  = SP_LO;
            end
            SP_LO: begin
                re_en     = 1'b1;
                re_idx    = IDX_L;
                we_en     = 1'b1;
                we_idx    = IDX_SP;
                done_next = 1'b1;
            end
            REJECT: begin
                done_next   = 1'b1;
                op_err_next = 1'b1;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Stalled: keep the step pending and blank everything it would drive.
        if (hold) begin
            state_next   = step;
            we_en        = 1'b0;
            re_en        = 1'b0;
            drv_en_next  = 1'b0;
            drv_val_next = 8'h00;
            hi_sel_next  = 1'b0;
            done_next    = 1'b0;
            op_err_next  = 1'b0;
        end

        // Ready rises one cycle after the done pulse: the edge that issues
        // the final step leaves state_reg in IDLE, and only the following
        // edge sees IDLE here.
        op_ready_next = (state_reg == IDLE) && !accept && !hold;
    end

    for (genvar gi = 0; gi < NUM_EN; gi++) begin : g_onehot
        assign we_next[gi] = we_en && (int'(we_idx) == gi);
        assign re_next[gi] = re_en && (int'(re_idx) == gi);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg       <= IDLE;
            src_idx_reg     <= IDX_W;
            dst_idx_reg     <= IDX_W;
            imm_reg         <= 8'h00;
            we_reg          <= '0;
            re_reg          <= '0;
            bus_drv_en_reg  <= 1'b0;
            bus_drv_val_reg <= 8'h00;
            hi_sel_reg      <= 1'b0;
            done_reg        <= 1'b0;
            op_err_reg      <= 1'b0;
            op_ready_reg    <= 1'b1;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                src_idx_reg <= dec_src;
                dst_idx_reg <= dec_dst;
                imm_reg     <= imm;
            end
            we_reg          <= we_next;
            re_reg          <= re_next;
            bus_drv_en_reg  <= drv_en_next;
            bus_drv_val_reg <= drv_val_next;
            hi_sel_reg      <= hi_sel_next;
            done_reg        <= done_next;
            op_err_reg      <= op_err_next;
            op_ready_reg    <= op_ready_next;
        end
    end

    assign WE          = we_reg;
    assign RE          = re_reg;
    assign bus_drv_en  = bus_drv_en_reg;
    assign bus_drv_val = bus_drv_val_reg;
    assign hi_sel      = hi_sel_reg;
    assign done        = done_reg;
    assign op_err      = op_err_reg;
    assign op_ready    = op_ready_reg;

endmodule

// File: tb/tb_z80_regbank_seq.sv
// Directed + soak bench for z80_regbank_seq. Expected output vectors are
// queued as stimulus is driven and popped one per clock when the DUT
// has produced that cycle's registered outputs.
module tb_z80_regbank_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        op_valid;
    logic        op_valid0;
    logic        hold;
    logic [7:0]  opcode;
    logic [7:0]  imm;

    logic        op_ready, bus_drv_en, hi_sel, done, op_err;
    logic [15:0] WE, RE;
    logic [7:0]  bus_drv_val;

    logic        op_ready0, bus_drv_en0, hi_sel0, done0, op_err0;
    logic [15:0] WE0, RE0;
    logic [7:0]  bus_drv_val0;

    always #5 clk = ~clk;

    z80_regbank_seq #(.NUM_EN(16), .SUPPORT_SPHL(1)) dut (
        .clk(clk), .reset(reset), .op_valid(op_valid), .op_ready(op_ready),
        .opcode(opcode), .imm(imm), .hold(hold), .WE(WE), .RE(RE),
        .bus_drv_en(bus_drv_en), .bus_drv_val(bus_drv_val), .hi_sel(hi_sel),
        .done(done), .op_err(op_err)
    );

    z80_regbank_seq #(.NUM_EN(16), .SUPPORT_SPHL(0)) dut0 (
        .clk(clk), .reset(reset), .op_valid(op_valid0), .op_ready(op_ready0),
        .opcode(opcode), .imm(imm), .hold(hold), .WE(WE0), .RE(RE0),
        .bus_drv_en(bus_drv_en0), .bus_drv_val(bus_drv_val0), .hi_sel(hi_sel0),
        .done(done0), .op_err(op_err0)
    );

    int checks = 0;
    int errors = 0;

    logic [44:0] exp_q[$];
    string       tag_q[$];

    logic [44:0] obs;
    logic [44:0] obs0;
    assign obs  = {WE, RE, bus_drv_en, bus_drv_val, hi_sel, done, op_err, op_ready};
    assign obs0 = {WE0, RE0, bus_drv_en0, bus_drv_val0, hi_sel0, done0, op_err0, op_ready0};

    // Vector layout: WE, RE, bus_drv_en, bus_drv_val, hi_sel, done, op_err, op_ready
    function automatic logic [44:0] ev(input logic [15:0] we, input logic [15:0] re,
                                       input logic drv, input logic [7:0] val,
                                       input logic hi, input logic dn,
                                       input logic err, input logic rdy);
        return {we, re, drv, val, hi, dn, err, rdy};
    endfunction

    localparam logic [44:0] IDLE_V = {16'h0000, 16'h0000, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1};
    localparam logic [44:0] BUSY_V = {16'h0000, 16'h0000, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};

    task automatic chk(input string tag, input logic [44:0] o, input logic [44:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, o, e);
            $error("check %s", tag);
        end
    endtask

    // Queue the expectation for the next edge, advance, then pop and compare.
    task automatic step(input string tag, input logic [44:0] e);
        logic [44:0] exp_v;
        string       t;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s observed=empty_queue expected=entry", tag);
        end else begin
            exp_v = exp_q.pop_front();
            t     = tag_q.pop_front();
            chk(t, obs, exp_v);
        end
        $display("cycle %s obs=%h", tag, obs);
    endtask

    function automatic bit inv_ok();
        return ($countones(RE) + int'(bus_drv_en) <= 1) &&
               ($countones(WE) <= 1) &&
               ((WE & RE) == 16'h0000) &&
               (WE[15:14] == 2'b00) && (RE[15:14] == 2'b00) &&
               (!op_err || done);
    endfunction

    logic [7:0] op_list [12];
    int  acc_cnt;
    int  done_cnt;
    bit  acc_now;

    initial begin
        op_list = '{8'h78, 8'h3E, 8'hF9, 8'h76, 8'h46, 8'h53,
                    8'h41, 8'h06, 8'h36, 8'h7F, 8'hFF, 8'h00};
        reset     = 1'b0;
        op_valid  = 1'b0;
        op_valid0 = 1'b0;
        hold      = 1'b0;
        opcode    = 8'h00;
        imm       = 8'h00;

        // Reset state
        step("reset_a", IDLE_V);
        step("reset_b", IDLE_V);
        chk("reset_dut0", obs0, IDLE_V);
        reset = 1'b1;
        step("release", IDLE_V);

        // LD A,B; opcode changed while busy must not be resampled
        opcode = 8'h78; op_valid = 1'b1;
        step("ldab_src", ev(16'h0001, 16'h0010, 0, 8'h00, 0, 0, 0, 0));
        opcode = 8'h41;
        step("ldab_dst", ev(16'h0004, 16'h0001, 0, 8'h00, 0, 1, 0, 0));
        op_valid = 1'b0;
        step("ldab_ready", IDLE_V);

        // LD A,n
        opcode = 8'h3E; imm = 8'h5A; op_valid = 1'b1;
        step("ldan_imm", ev(16'h0004, 16'h0000, 1, 8'h5A, 0, 1, 0, 0));
        op_valid = 1'b0;
        step("ldan_ready", IDLE_V);

        // LD SP,HL supported
        opcode = 8'hF9; op_valid = 1'b1;
        step("sphl_hi", ev(16'h1000, 16'h0100, 0, 8'h00, 1, 0, 0, 0));
        op_valid = 1'b0;
        step("sphl_lo", ev(16'h1000, 16'h0200, 0, 8'h00, 0, 1, 0, 0));
        step("sphl_ready", IDLE_V);

        // LD SP,HL unsupported instance
        op_valid0 = 1'b1;
        step("main_idle_a", IDLE_V);
        chk("sphl0_reject", obs0, ev(16'h0000, 16'h0000, 0, 8'h00, 0, 1, 1, 0));
        op_valid0 = 1'b0;
        step("main_idle_b", IDLE_V);
        chk("sphl0_ready", obs0, IDLE_V);

        // HALT and LD B,(HL) rejected
        opcode = 8'h76; op_valid = 1'b1;
        step("halt_reject", ev(16'h0000, 16'h0000, 0, 8'h00, 0, 1, 1, 0));
        op_valid = 1'b0;
        step("halt_ready", IDLE_V);
        opcode = 8'h46; op_valid = 1'b1;
        step("ldbhl_reject", ev(16'h0000, 16'h0000, 0, 8'h00, 0, 1, 1, 0));
        op_valid = 1'b0;
        step("ldbhl_ready", IDLE_V);

        // LD D,E with hold during MV_DST
        opcode = 8'h53; op_valid = 1'b1;
        step("ldde_src", ev(16'h0001, 16'h0080, 0, 8'h00, 0, 0, 0, 0));
        op_valid = 1'b0; hold = 1'b1;
        step("ldde_hold1", BUSY_V);
        step("ldde_hold2", BUSY_V);
        step("ldde_hold3", BUSY_V);
        hold = 1'b0;
        step("ldde_dst", ev(16'h0040, 16'h0001, 0, 8'h00, 0, 1, 0, 0));
        step("ldde_ready", IDLE_V);

        // Back-to-back LD r,n with op_valid held high
        opcode = 8'h06; imm = 8'h11; op_valid = 1'b1;
        step("b2b_first", ev(16'h0010, 16'h0000, 1, 8'h11, 0, 1, 0, 0));
        step("b2b_gap", IDLE_V);
        step("b2b_second", ev(16'h0010, 16'h0000, 1, 8'h11, 0, 1, 0, 0));
        op_valid = 1'b0;
        step("b2b_ready", IDLE_V);

        // hold in IDLE blocks acceptance
        hold = 1'b1;
        step("hidle_a", BUSY_V);
        opcode = 8'h3E; imm = 8'hC3; op_valid = 1'b1;
        step("hidle_b", BUSY_V);
        hold = 1'b0;
        step("hidle_rel", IDLE_V);
        step("hidle_imm", ev(16'h0004, 16'h0000, 1, 8'hC3, 0, 1, 0, 0));
        op_valid = 1'b0;
        step("hidle_ready", IDLE_V);

        // Reset during MV_SRC of LD B,C
        opcode = 8'h41; op_valid = 1'b1;
        step("rst_src", ev(16'h0001, 16'h0020, 0, 8'h00, 0, 0, 0, 0));
        op_valid = 1'b0; reset = 1'b0;
        step("rst_abort", IDLE_V);
        reset = 1'b1;
        step("rst_after", IDLE_V);

        // Random soak: invariants every cycle, one done per accepted opcode
        acc_cnt  = 0;
        done_cnt = 0;
        for (int i = 0; i < 300; i++) begin
            op_valid = ($urandom_range(0, 1) == 1);
            opcode   = ($urandom_range(0, 1) == 1) ? op_list[$urandom_range(0, 11)]
                                                    : 8'($urandom);
            imm      = 8'($urandom);
            hold     = ($urandom_range(0, 3) == 0);
            acc_now  = op_valid && op_ready;
            @(posedge clk);
            #1;
            if (acc_now) acc_cnt++;
            if (done) done_cnt++;
            checks++;
            assert (inv_ok() === 1'b1) else begin
                errors++;
                $display("FAIL soak_inv_%0d observed WE=%h RE=%h drv=%b required=onehot_exclusive",
                         i, WE, RE, bus_drv_en);
                $error("soak invariant");
            end
        end
        op_valid = 1'b0;
        hold     = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (done) done_cnt++;
        end
        checks++;
        assert (done_cnt === acc_cnt) else begin
            errors++;
            $display("FAIL soak_done_count observed=%0d expected=%0d", done_cnt, acc_cnt);
            $error("soak done count");
        end
        $display("soak accepts=%0d dones=%0d", acc_cnt, done_cnt);
        checks++;
        assert (obs === IDLE_V) else begin
            errors++;
            $display("FAIL soak_end_idle observed=%h expected=%h", obs, IDLE_V);
            $error("soak end idle");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
